// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 set-2 scan code receiver in the pixel clock domain.
// Optional auto-repeat suppression when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_rel,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [14:0]   WD_MAX   = 15'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [14:0]   wd_q, wd_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    key_in_q, key_in_d;
  logic          key_ext_q, key_ext_d;
  logic          key_en_q, key_en_d;
  logic          key_rel_q, key_rel_d;
  logic          frame_err_q, frame_err_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]    last_make_q, last_make_d;
  logic          lm_vld_q, lm_vld_d;
`endif

  logic fall;
  logic bit_in;
  logic frame_done;
  logic frame_ok;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = filt_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_in_d    = key_in_q;
    key_ext_d   = key_ext_q;
    key_en_d    = 1'b0;
    key_rel_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    last_make_d = last_make_q;
    lm_vld_d    = lm_vld_q;
`endif
    fall       = 1'b0;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    bit_in     = dat_sync_q[1];

    // Level flips only after FILTER_LEN consecutive disagreeing samples.
    if (clk_sync_q[1] == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_MAX) begin
      filt_d     = clk_sync_q[1];
      filt_cnt_d = '0;
      fall       = filt_q;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    if (fall || state_q == S_IDLE) wd_d = '0;
    else                           wd_d = wd_q + 15'd1;

    case (state_q)
      S_IDLE: begin
        if (fall && !bit_in) state_d = S_START;
      end
      S_START: begin
        bit_cnt_d = '0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          frame_done = 1'b1;
          frame_ok   = (^shift_q ^ par_q) & bit_in;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!fall && state_q != S_IDLE && wd_q == WD_MAX) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end

    if (frame_done) begin
      if (!frame_ok) begin
        frame_err_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end else if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        key_in_d   = shift_q;
        key_ext_d  = ext_pend_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (brk_pend_q) begin
          key_rel_d = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (last_make_q == {ext_pend_q, shift_q}) lm_vld_d = 1'b0;
`endif
        end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
          key_en_d    = !(lm_vld_q && last_make_q == {ext_pend_q, shift_q});
          last_make_d = {ext_pend_q, shift_q};
          lm_vld_d    = 1'b1;
`else
          key_en_d = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      wd_q        <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_in_q    <= 8'h00;
      key_ext_q   <= 1'b0;
      key_en_q    <= 1'b0;
      key_rel_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make_q <= '0;
      lm_vld_q    <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      wd_q        <= wd_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_in_q    <= key_in_d;
      key_ext_q   <= key_ext_d;
      key_en_q    <= key_en_d;
      key_rel_q   <= key_rel_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make_q <= last_make_d;
      lm_vld_q    <= lm_vld_d;
`endif
    end
  end

  assign key_in    = key_in_q;
  assign key_ext   = key_ext_q;
  assign key_en    = key_en_q;
  assign key_rel   = key_rel_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx with a byte-level reference model.
module tb_ps2_scancode_rx;
  localparam int FL = 8;
  localparam int TO = 2000;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_in;
  logic       key_en, key_rel, key_ext, frame_err;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .iCLK(iCLK), .iRST(iRST), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_in(key_in), .key_en(key_en), .key_rel(key_rel), .key_ext(key_ext),
    .frame_err(frame_err)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {int kind; logic [7:0] code; logic ext;} ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_en = 0;
  int n_rel = 0;

  // Reference model: byte-level decoding rules.
  logic       m_ext_pend, m_brk_pend, m_ext, lm_v;
  logic [7:0] m_key;
  logic [8:0] lm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_ext_pend = 0; m_brk_pend = 0; m_ext = 0; m_key = 8'h00; lm_v = 0; lm = '0;
  endtask

  task automatic push(input int kind);
    ev_t e;
    e.kind = kind; e.code = m_key; e.ext = m_ext;
    exp_q.push_back(e);
  endtask

  task automatic model_err();
    push(2);
    m_ext_pend = 0; m_brk_pend = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    bit suppress;
    if (!ok) model_err();
    else if (b == 8'hE0) m_ext_pend = 1;
    else if (b == 8'hF0) m_brk_pend = 1;
    else begin
      m_key = b; m_ext = m_ext_pend;
      if (m_brk_pend) begin
        push(1);
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (lm == {m_ext, b}) lm_v = 0;
`endif
      end else begin
        suppress = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        suppress = lm_v && (lm == {m_ext, b});
        lm = {m_ext, b}; lm_v = 1;
`endif
        if (!suppress) push(0);
      end
      m_ext_pend = 0; m_brk_pend = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iCLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                            input int nbits, input int extra_at, input int glitch_at);
    logic [10:0] bits;
    int h;
    bits = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      h = $urandom_range(14, 22);
      ps2_data = bits[i];
      if (i == glitch_at) begin
        cyc(h / 2); ps2_clk = 0; cyc(2); ps2_clk = 1; cyc(h / 2);
      end else cyc(h);
      if (i == extra_at) begin
        ps2_clk = 0; cyc(FL + 4); ps2_clk = 1; cyc(h);
      end
      ps2_clk = 0; cyc(h); ps2_clk = 1;
    end
    cyc(16);
    ps2_data = 1;
    cyc(20);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_frame(b, 1);
    send_frame(b, 0, 1, 11, -1, -1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_key_in"}, 32'(key_in), 0);
    chk({tag, "_key_en"}, 32'(key_en), 0);
    chk({tag, "_key_rel"}, 32'(key_rel), 0);
    chk({tag, "_key_ext"}, 32'(key_ext), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  always @(negedge iCLK) begin
    if (!iRST && (key_en || key_rel || frame_err)) begin
      ev_t e;
      int kind;
      kind = key_en ? 0 : (key_rel ? 1 : 2);
      if (key_en) n_en++;
      if (key_rel) n_rel++;
      chk("strobe_onehot", 32'(int'(key_en) + int'(key_rel) + int'(frame_err)), 1);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got kind %0d key_in 0x%0h, expected no strobe", kind, key_in);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", 32'(kind), 32'(e.kind));
        chk("key_in", 32'(key_in), 32'(e.code));
        chk("key_ext", 32'(key_ext), 32'(e.ext));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int en0, rel0;
    logic [7:0] b;
    bit bp, sv;
    model_reset();
    cyc(5); #1;
    chk_outputs_zero("reset");
    @(posedge iCLK); iRST = 0;
    cyc(20);

    send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);

    model_frame(8'h6B, 0);
    send_frame(8'h6B, 1, 1, 11, -1, -1);
    send_byte(8'hE0); send_byte(8'h6B);

    model_err();
    send_frame(8'h1C, 0, 1, 6, -1, -1);
    cyc(TO + 10);
    send_byte(8'h1C);

    model_frame(8'h1C, 1);
    send_frame(8'h1C, 0, 1, 11, -1, 4);
    model_frame(8'h1C, 0);
    send_frame(8'h1C, 0, 1, 11, 3, -1);

    send_frame(8'h1C, 0, 1, 5, -1, -1);
    @(posedge iCLK); iRST = 1;
    cyc(3); #1;
    chk_outputs_zero("midframe_reset");
    model_reset();
    @(posedge iCLK); iRST = 0;
    cyc(20);

    en0 = n_en; rel0 = n_rel;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    cyc(20);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_en_count", 32'(n_en - en0), 2);
`else
    chk("typematic_en_count", 32'(n_en - en0), 4);
`endif
    chk("typematic_rel_count", 32'(n_rel - rel0), 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 19) == 0);
      sv = ($urandom_range(0, 19) != 0);
      model_frame(b, !bp && sv);
      send_frame(b, bp, sv, 11, -1, -1);
    end

    cyc(100);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
